ram_arbiter: RTL

- Two-port arbiter and sequencer in front of the 128x16 data RAM of the hack CPU.
- RAM read is combinational; RAM write commits on the clock edge.
- Shares the single RAM port between requester A (CPU data access) and requester B (loader/debug) using round-robin arbitration and a req/ack handshake.
- After reset, runs a clear sequence that zeroes every RAM word before it accepts any request.

---
 rtl/ram_arbiter_if.sv | 44 ++++
 rtl/ram_arbiter.sv | 93 +++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester A/B handshake and RAM port bundle for ram_arbiter
interface ram_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 7
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_add;
  logic [WIDTH-1:0]  a_wdata;
  logic              a_ack;
  logic [WIDTH-1:0]  a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_add;
  logic [WIDTH-1:0]  b_wdata;
  logic              b_ack;
  logic [WIDTH-1:0]  b_rdata;

  logic [WIDTH-1:0]  ram_out;
  logic [WIDTH-1:0]  ram_in;
  logic [ADDR_W-1:0] ram_add;
  logic              write;

  // arbiter side
  modport slave (
    input  a_req, a_we, a_add, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_add, b_wdata,
    output b_ack, b_rdata,
    input  ram_out,
    output ram_in, ram_add, write
  );

  // requesters plus the RAM itself
  modport master (
    output a_req, a_we, a_add, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_add, b_wdata,
    input  b_ack, b_rdata,
    output ram_out,
    input  ram_in, ram_add, write
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-port arbiter and post-reset clear sequencer for the 128x16 data RAM
module ram_arbiter #(
  parameter int WIDTH          = 16,
  parameter int ADDR_W         = 7,
  parameter int DEPTH          = 128,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          busy,
  ram_arbiter_if.slave  bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [ADDR_W-1:0] LAST_ADD    = ADDR_W'(DEPTH - 1);
  localparam logic              PORT_A      = 1'b0;
  localparam logic              PORT_B      = 1'b1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] hold_add;
  logic [WIDTH-1:0]  hold_din;
  logic              last_grant;
  logic              elig_a, elig_b;
  logic              grant_a, grant_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && counter == LAST_ADD) state_nxt = RUN;
  end

  // Outputs are gated by reset_n so write/address drop the moment reset asserts.
  always_comb begin
    busy        = (state == CLEAR);
    elig_a      = bus.a_req & ~bus.a_ack;
    elig_b      = bus.b_req & ~bus.b_ack;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    bus.write   = 1'b0;
    bus.ram_add = hold_add;
    bus.ram_in  = hold_din;
    if (reset_n) begin
      if (state == CLEAR) begin
        bus.write   = 1'b1;
        bus.ram_add = counter;
        bus.ram_in  = '0;
      end else begin
        grant_a = elig_a & (~elig_b | (last_grant == PORT_B));
        grant_b = elig_b & ~grant_a;
        if (grant_a) begin
          bus.write   = bus.a_we;
          bus.ram_add = bus.a_add;
          bus.ram_in  = bus.a_wdata;
        end else if (grant_b) begin
          bus.write   = bus.b_we;
          bus.ram_add = bus.b_add;
          bus.ram_in  = bus.b_wdata;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter     <= '0;
      hold_add    <= '0;
      hold_din    <= '0;
      last_grant  <= PORT_B;
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
    end else begin
      hold_add  <= bus.ram_add;
      hold_din  <= bus.ram_in;
      bus.a_ack <= grant_a;
      bus.b_ack <= grant_b;
      if (state == CLEAR)          counter     <= counter + ADDR_W'(1);
      if (grant_a && !bus.a_we)    bus.a_rdata <= bus.ram_out;
      if (grant_b && !bus.b_we)    bus.b_rdata <= bus.ram_out;
      if (grant_a)                 last_grant  <= PORT_A;
      else if (grant_b)            last_grant  <= PORT_B;
    end
  end

endmodule
